udp_filter_arb: RTL
===================

# udp_filter_arb

Frame-granular round-robin arbiter and sequencer that shares one `udp_filter` instance between `PORT_NR` AXI-Stream ingress ports. It grants one whole frame at a time and paces beats into the filter's `en_i`/`frame_i`/`frame_last_i` inputs so that the filter's FSM never drops a beat. It also resets the filter after runt frames, then waits for the filter's FIFO to drain before granting the next frame. It sits between the MAC-side stream mux and `udp_filter`.

## Interface
- `DATA_WIDTH`, 64, beat width; must equal the filter's `DATA_WIDTH`.
- `PORT_NR`, 4, number of ingress ports (2..8).
- `CNT_WIDTH`, 32, width of the statistics counters.

Ports:
- `clk_i`  in  1  single clock.
- `s_rst_i`  in  1  reset; synchronous, active-high.
- `s_axis_tdata_i`  in  PORT_NR*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid_i`  in  PORT_NR  per-port valid.
- `s_axis_tlast_i`  in  PORT_NR  per-port last.
- `s_axis_tready_o`  out  PORT_NR  per-port ready; one-hot or zero.
- `flt_en_o`  out  1  drives filter `en_i`.
- `flt_frame_o`  out  DATA_WIDTH  drives filter `frame_i`.
- `flt_frame_last_o`  out  1  drives filter `frame_last_i`.
- `flt_rst_n_o`  out  1  drives filter `s_rst_n_i`.
- `flt_frame_valid_i`  in  1  from filter `frame_valid_o`.
- `grant_o`  out  PORT_NR  one-hot current owner; 0 when idle.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, START, BEAT, BUBBLE, DRAIN, RUNT_RST.
- **IDLE**
  - If any `s_axis_tvalid_i` bit is set, grant the first requesting port at or after `rr_ptr` (wrapping modulo `PORT_NR`).
  - Latch the grant, set `rr_ptr` = granted+1 (wrapping), clear `beat_cnt`, go to START.
- **START**
  - `flt_en_o`=1 and all `tready`=0. This advances the filter from its IDLE to its MAC state without consuming a beat.
  - Next state: BEAT.
- **BEAT**
  - Granted `tready`=1.
  - `flt_en_o` = granted `tvalid`.
  - `flt_frame_o` = granted `tdata`.
  - `flt_frame_last_o` = granted `tvalid & tlast`.
  - Each accepted beat increments `beat_cnt`, saturating at 5.
- **Beat-accept transitions** (first match wins):
  - tlast with pre-increment `beat_cnt` < 4 (frame of 1..4 beats, runt) → RUNT_RST.
  - tlast otherwise: if `flt_frame_valid_i`=1 in that cycle → DRAIN, else → IDLE.
  - Non-last beat with post-increment `beat_cnt` ∈ {2,3,4} → BUBBLE.
  - Otherwise stay in BEAT.
- **BUBBLE**
  - `flt_en_o`=0 and `tready`=0 for exactly one cycle, then back to BEAT.
  - This absorbs the filter's unconditional WRONG_FRAME→LAST step, so a following last beat is never lost.
- **DRAIN**
  - All outputs are idle. Wait until `flt_frame_valid_i`=0 (filter FIFO empty), then go to IDLE.
- **RUNT_RST**
  - `flt_rst_n_o`=0 for one cycle (filter FSM and FIFO reset), then IDLE.
- `flt_rst_n_o` = ~`s_rst_i` & (state != RUNT_RST).
- The grant is held for the whole frame. Non-granted ports see `tready`=0 in every state.
- Simultaneous requests are resolved by `rr_ptr` only. A request that appears while the block is busy waits for IDLE.
- Reset mid-frame: FSM goes to IDLE, `rr_ptr`=0, `beat_cnt`=0. The filter is reset by the same cycle through `flt_rst_n_o`. The partial frame is not resumed; the upstream source must discard it.

## Timing
- Reset values:
  - `s_axis_tready_o`=0, `flt_en_o`=0, `flt_frame_o`=0, `flt_frame_last_o`=0.
  - `flt_rst_n_o`=0 (while `s_rst_i`=1), `grant_o`=0, `busy_o`=0.
  - All counters 0.
- `tready`, `flt_en_o`, `flt_frame_o` and `flt_frame_last_o` are combinational from state and granted-port inputs. `flt_frame_o` is 0 outside BEAT.
- Arbitration latency: request seen in IDLE → START on the next cycle → first beat accepted no earlier than 2 cycles after the request.
- Fixed overhead per frame: 1 (IDLE) + 1 (START) + 3 (BUBBLE) cycles, plus DRAIN length.
- Back-to-back frames always pass through IDLE for at least one cycle.

## Configuration
- `UDP_FILTER_ARB_STATS_EN` defined:
  - Adds outputs `stat_frames_o`, `stat_runts_o` and `stat_passed_o` (each `CNT_WIDTH` bits, saturating, cleared by `s_rst_i`).
  - `stat_frames_o` increments on every granted frame.
  - `stat_runts_o` increments on entry to RUNT_RST.
  - `stat_passed_o` increments on a last beat with `flt_frame_valid_i`=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Single good frame:** 8-beat frame on port 0, filter model returns `frame_valid`=1 at the last beat and holds it 3 cycles.
  - Required: START pulse, bubbles after beats 2, 3 and 4, all 8 beats presented once each, DRAIN 3 cycles, `busy_o` falls.
- **Round robin:** ports 0, 1 and 3 all request continuously.
  - Required: grant order 0,1,3,0; `grant_o` one-hot, stable for each whole frame.
- **Runt frame:** 3-beat frame on port 2.
  - Required: `flt_rst_n_o`=0 for exactly one cycle after beat 3; next grant proceeds normally; `stat_runts_o`=1 when `UDP_FILTER_ARB_STATS_EN` is defined.
- **Wrong frame:** 6-beat frame with bad ethertype, `frame_valid` never asserted.
  - Required: no DRAIN; IDLE one cycle after the last beat; `flt_frame_last_o` asserted exactly once.
- **Upstream stalls:** `tvalid` toggled 1-0-1 during BEAT.
  - Required: `flt_en_o` mirrors `tvalid`; `beat_cnt` advances only on accepted beats.
- **Reset mid-frame:** `s_rst_i` pulsed at beat 5.
  - Required: next cycle all outputs at reset values, `rr_ptr`=0; a new frame on port 1 is granted cleanly.

Source files
------------

// File: rtl/udp_filter_arb.sv
// udp_filter_arb: frame-granular round-robin arbiter that shares one udp_filter
// between PORT_NR AXI-Stream ingress ports. One whole frame is granted at a time,
// and beats are paced so that the filter FSM never drops one. After a runt frame
// the filter is reset; after a passed frame the arbiter waits for the filter FIFO
// to drain before granting again.
// Optional statistics counters: define UDP_FILTER_ARB_STATS_EN.
module udp_filter_arb #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned PORT_NR    = 4,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                            clk_i,
   input  logic                            s_rst_i,
   input  logic [PORT_NR*DATA_WIDTH-1:0]   s_axis_tdata_i,
   input  logic [PORT_NR-1:0]              s_axis_tvalid_i,
   input  logic [PORT_NR-1:0]              s_axis_tlast_i,
   output logic [PORT_NR-1:0]              s_axis_tready_o,
   output logic                            flt_en_o,
   output logic [DATA_WIDTH-1:0]           flt_frame_o,
   output logic                            flt_frame_last_o,
   output logic                            flt_rst_n_o,
   input  logic                            flt_frame_valid_i,
   output logic [PORT_NR-1:0]              grant_o,
   output logic                            busy_o
`ifdef UDP_FILTER_ARB_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]            stat_frames_o,
   output logic [CNT_WIDTH-1:0]            stat_runts_o,
   output logic [CNT_WIDTH-1:0]            stat_passed_o
`endif
);

   localparam int unsigned IdxW = (PORT_NR > 1) ? $clog2(PORT_NR) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBeat,
      StBubble,
      StDrain,
      StRuntRst
   } state_t;

   state_t                state;
   logic [IdxW-1:0]       grant_idx;
   logic [IdxW-1:0]       rr_ptr;
   logic [2:0]            beat_cnt;
   logic [2:0]            beat_inc;

   int unsigned           cand;
   logic [IdxW-1:0]       cand_idx;
   logic [IdxW-1:0]       req_idx;
   logic                  req_found;

   logic                  g_valid;
   logic                  g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  in_beat;
   logic                  accept;

   // Find the first requesting port at or after rr_ptr, wrapping around.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < PORT_NR; i++) begin
         cand     = (32'(rr_ptr) + i) % PORT_NR;
         cand_idx = IdxW'(cand);
         if (!req_found && s_axis_tvalid_i[cand_idx]) begin
            req_found = 1'b1;
            req_idx   = cand_idx;
         end
      end
   end

   // Granted-port view and combinational outputs to the ports and the filter.
   always_comb begin
      g_valid          = s_axis_tvalid_i[grant_idx];
      g_last           = s_axis_tlast_i[grant_idx];
      g_data           = s_axis_tdata_i[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      in_beat          = (state == StBeat);
      accept           = in_beat & g_valid;
      beat_inc         = beat_cnt + 3'd1;
      s_axis_tready_o  = in_beat ? grant_o : '0;
      // START pulses en without data to move the filter from IDLE to its MAC state.
      flt_en_o         = (state == StStart) | accept;
      flt_frame_o      = in_beat ? g_data : '0;
      flt_frame_last_o = accept & g_last;
      flt_rst_n_o      = ~s_rst_i & (state != StRuntRst);
      busy_o           = (state != StIdle);
   end

   // Frame sequencer: grant, pace beats, insert bubbles, drain or reset the filter.
   always_ff @(posedge clk_i) begin
      if (s_rst_i) begin
         state     <= StIdle;
         grant_o   <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (req_found) begin
                  grant_o   <= PORT_NR'(1) << req_idx;
                  grant_idx <= req_idx;
                  rr_ptr    <= (req_idx == IdxW'(PORT_NR - 1)) ? '0 : req_idx + 1'b1;
                  beat_cnt  <= '0;
                  state     <= StStart;
               end
            end
            StStart: begin
               state <= StBeat;
            end
            StBeat: begin
               if (accept) begin
                  if (beat_cnt != 3'd5) begin
                     beat_cnt <= beat_inc;
                  end
                  if (g_last) begin
                     if (beat_cnt < 3'd4) begin
                        state <= StRuntRst;
                     end else if (flt_frame_valid_i) begin
                        state <= StDrain;
                     end else begin
                        state   <= StIdle;
                        grant_o <= '0;
                     end
                  end else if (beat_inc >= 3'd2 && beat_inc <= 3'd4) begin
                     // Give the filter its unconditional WRONG_FRAME->LAST step.
                     state <= StBubble;
                  end
               end
            end
            StBubble: begin
               state <= StBeat;
            end
            StDrain: begin
               if (!flt_frame_valid_i) begin
                  state   <= StIdle;
                  grant_o <= '0;
               end
            end
            StRuntRst: begin
               state   <= StIdle;
               grant_o <= '0;
            end
            default: begin
               state   <= StIdle;
               grant_o <= '0;
            end
         endcase
      end
   end

`ifdef UDP_FILTER_ARB_STATS_EN
   logic frame_evt;
   logic runt_evt;
   logic pass_evt;

   // Statistics event decode.
   always_comb begin
      frame_evt = (state == StIdle) & req_found;
      runt_evt  = accept & g_last & (beat_cnt < 3'd4);
      pass_evt  = accept & g_last & flt_frame_valid_i;
   end

   // Saturating statistics counters.
   always_ff @(posedge clk_i) begin
      if (s_rst_i) begin
         stat_frames_o <= '0;
         stat_runts_o  <= '0;
         stat_passed_o <= '0;
      end else begin
         if (frame_evt && stat_frames_o != '1) stat_frames_o <= stat_frames_o + 1'b1;
         if (runt_evt && stat_runts_o != '1)   stat_runts_o  <= stat_runts_o + 1'b1;
         if (pass_evt && stat_passed_o != '1)  stat_passed_o <= stat_passed_o + 1'b1;
      end
   end
`endif

endmodule
